// File: rtl/router_pkg.sv
// Shared router definitions: byte/depth defaults, header field layout,
// the stored FIFO word type and the header length-to-count helper.
// No ports; imported by router_fifo_if, router_fifo_mem and router_fifo.
package router_pkg;

  localparam int ROUTER_WIDTH = 8;
  localparam int ROUTER_DEPTH = 16;

  // Header byte layout: payload length in [7:2], destination address in [1:0]
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  // One storage word: header tag above the data byte
  typedef struct packed {
    logic                    tag;
    logic [ROUTER_WIDTH-1:0] data;
  } fifo_word_t;

  // Bytes still to emit after a header: payload length plus the parity byte
  function automatic logic [6:0] hdr_count(input logic [ROUTER_WIDTH-1:0] hdr);
    return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Handshake bundle between the synchroniser/destination side and one router_fifo.
// master: drives soft_reset, write_enb, read_enb, lfd_state, data_in; sees data_out, full, empty.
// slave : the FIFO side of the same signals.
interface router_fifo_if
  import router_pkg::*;
#(
  parameter int WIDTH = ROUTER_WIDTH
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty
  );
endinterface

// File: rtl/router_fifo_mem.sv
// Simple dual-port register file of tagged words: synchronous write, asynchronous read.
// Ports: clock; i_wr_en/i_wr_addr/i_wr_data write port; i_rd_addr -> o_rd_data read port.
// Contents are not reset; the owning FIFO's pointers define what is valid.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  fifo_word_t    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output fifo_word_t    o_rd_data
);

  fifo_word_t r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_fifo.sv
// Per-destination router output buffer: header-tagged FIFO that drives data_out idle between packets.
// Ports: clock, reset (async, active-high); bus (router_fifo_if.slave): soft_reset, write_enb,
// read_enb, lfd_state, data_in in; data_out (registered), full, empty out.
// ROUTER_FIFO_TRISTATE_EN: when defined, idle data_out is high-impedance instead of zero.
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_DEPTH,
  parameter int WIDTH = ROUTER_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  router_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [6:0]       r_count;
  logic [WIDTH-1:0] r_data_out;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  fifo_word_t       w_wr_word;
  fifo_word_t       w_rd_word;
  logic [6:0]       w_count_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_idle_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Flags are taken before the edge, so a simultaneous push/pop never bypasses
  assign w_push = bus.write_enb && !w_full  && !bus.soft_reset;
  assign w_pop  = bus.read_enb  && !w_empty && !bus.soft_reset;

  assign w_wr_word = '{tag: bus.lfd_state, data: bus.data_in};

  router_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock     (clock),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_word),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Read-side packet tracking: count is the number of bytes still owed to the
  // current packet; a non-header word arriving with nothing owed is dropped.
  always_comb begin
    w_count_nxt = r_count;
    w_data_nxt  = r_data_out;
    w_idle_nxt  = 1'b0;
    if (bus.soft_reset) begin
      w_count_nxt = '0;
      w_idle_nxt  = 1'b1;
    end else if (w_pop) begin
      if (w_rd_word.tag) begin
        // A header always restarts tracking, abandoning any unfinished packet
        w_data_nxt  = w_rd_word.data;
        w_count_nxt = hdr_count(w_rd_word.data);
      end else if (r_count != '0) begin
        w_data_nxt  = w_rd_word.data;
        w_count_nxt = r_count - 7'd1;
      end else begin
        w_idle_nxt = 1'b1;
      end
    end else if (r_count == '0) begin
      w_idle_nxt = 1'b1;
    end
    if (w_idle_nxt) w_data_nxt = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_data_out <= w_data_nxt;
    end
  end

`ifdef ROUTER_FIFO_TRISTATE_EN
  logic r_drive;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_drive <= 1'b0;
    else       r_drive <= !w_idle_nxt;
  end

  assign bus.data_out = r_drive ? r_data_out : {WIDTH{1'bz}};
`else
  assign bus.data_out = r_data_out;
`endif

  assign bus.full  = w_full;
  assign bus.empty = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed packet scenarios followed by random traffic,
// each cycle compared against a queue-based packet model.
// Ports: none (top-level bench).
module tb_router_fifo;
  import router_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  router_fifo_if bus ();

  router_fifo dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         tag;
    logic [7:0] b;
  } mword_t;

  mword_t     q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  logic [7:0] idle_v;
  int         checks;
  int         errors;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_dout = idle_v;
  endtask

  // Apply one cycle of inputs, advance the model at the same edge, then compare
  task automatic step(input bit we, input bit re, input bit lfd, input logic [7:0] din,
                      input bit srst, input string tag);
    bit     was_full;
    bit     was_empty;
    mword_t w;
    bus.write_enb  = we;
    bus.read_enb   = re;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.soft_reset = srst;
    @(posedge clock);
    if (srst) begin
      model_clear();
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (re && !was_empty) begin
        w = q.pop_front();
        if (w.tag) begin
          m_dout = w.b;
          m_cnt  = int'(w.b >> 2) + 1;
        end else if (m_cnt > 0) begin
          m_dout = w.b;
          m_cnt  = m_cnt - 1;
        end else begin
          m_dout = idle_v;
        end
      end else if (m_cnt == 0) begin
        m_dout = idle_v;
      end
      if (we && !was_full) q.push_back('{lfd, din});
    end
    #1;
    chk({tag, ".dout"},  bus.data_out, m_dout);
    chk({tag, ".empty"}, {7'd0, bus.empty}, {7'd0, q.size() == 0});
    chk({tag, ".full"},  {7'd0, bus.full},  {7'd0, q.size() == 16});
  endtask

  task automatic push(input bit lfd, input logic [7:0] d, input string tag);
    step(1'b1, 1'b0, lfd, d, 1'b0, tag);
  endtask

  task automatic pop(input string tag);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, tag);
  endtask

  initial begin
    logic [7:0] pkt1 [5];
    bit         r_we;
    bit         r_re;
    checks = 0;
    errors = 0;
`ifdef ROUTER_FIFO_TRISTATE_EN
    idle_v = 8'hzz;
`else
    idle_v = 8'h00;
`endif
    pkt1[0] = 8'h0C; pkt1[1] = 8'hA1; pkt1[2] = 8'hA2; pkt1[3] = 8'hA3; pkt1[4] = 8'h5E;

    // Reset state
    reset          = 1'b1;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    #12;
    chk("rst.dout",  bus.data_out, idle_v);
    chk("rst.empty", {7'd0, bus.empty}, 8'd1);
    chk("rst.full",  {7'd0, bus.full},  8'd0);
    model_clear();
    reset = 1'b0;

    // Single packet: header 0C announces 3 payload bytes plus parity
    for (int i = 0; i < 5; i++) push(i == 0, pkt1[i], "pkt1.push");
    for (int i = 0; i < 5; i++) begin
      pop("pkt1.pop");
      chk("pkt1.seq", bus.data_out, pkt1[i]);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "pkt1.idle");
    chk("pkt1.idle_dout", bus.data_out, idle_v);
    chk("pkt1.idle_empty", {7'd0, bus.empty}, 8'd1);

    // Fill to 16 (long header keeps every payload live), then overflow
    push(1'b1, 8'hFC, "fill.push");
    for (int i = 0; i < 15; i++) push(1'b0, 8'h10 + 8'(i), "fill.push");
    chk("fill.full16", {7'd0, bus.full}, 8'd1);
    push(1'b0, 8'hEE, "fill.push17");
    chk("fill.full17", {7'd0, bus.full}, 8'd1);

    // Full: simultaneous push/pop pops the header and drops the push
    step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, "full.pushpop");
    chk("full.pushpop_dout", bus.data_out, 8'hFC);
    chk("full.pushpop_full", {7'd0, bus.full}, 8'd0);
    for (int i = 0; i < 15; i++) begin
      pop("fill.pop");
      chk("fill.order", bus.data_out, 8'h10 + 8'(i));
    end

    // Empty: simultaneous push/pop takes only the push; packet still open so data_out holds
    step(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, "empty.pushpop");
    chk("empty.pushpop_dout", bus.data_out, 8'h1E);
    chk("empty.pushpop_empty", {7'd0, bus.empty}, 8'd0);
    pop("empty.next");
    chk("empty.next_dout", bus.data_out, 8'h3C);

    // Soft reset mid-packet, with a push and pop that must be dropped
    push(1'b1, 8'h14, "srst.push");
    for (int i = 0; i < 5; i++) push(1'b0, 8'hB1 + 8'(i), "srst.push");
    for (int i = 0; i < 3; i++) pop("srst.pop");
    step(1'b1, 1'b1, 1'b0, 8'h99, 1'b1, "srst.flush");
    chk("srst.empty", {7'd0, bus.empty}, 8'd1);
    chk("srst.dout", bus.data_out, idle_v);
    push(1'b1, 8'h04, "srst.newhdr");
    pop("srst.newpop");
    chk("srst.newhdr_dout", bus.data_out, 8'h04);

    // Asynchronous reset mid-cycle with 5 words stored and data_out driven
    push(1'b1, 8'h10, "arst.push");
    for (int i = 0; i < 5; i++) push(1'b0, 8'hC0 + 8'(i), "arst.push");
    pop("arst.pop");
    chk("arst.pre_dout", bus.data_out, 8'h10);
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.dout",  bus.data_out, idle_v);
    chk("arst.empty", {7'd0, bus.empty}, 8'd1);
    chk("arst.full",  {7'd0, bus.full},  8'd0);
    model_clear();
    #3;
    reset = 1'b0;

    // Random traffic: a fill-biased phase then a drain-biased phase
    for (int i = 0; i < 600; i++) begin
      if (i < 300) begin
        r_we = ($urandom_range(3) != 0);
        r_re = ($urandom_range(3) == 0);
      end else begin
        r_we = ($urandom_range(3) == 0);
        r_re = ($urandom_range(3) != 0);
      end
      step(r_we, r_re, $urandom_range(4) == 0, 8'($urandom), $urandom_range(59) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
